ub_access_ctrl: RTL and testbench
=================================

// Module: ub_access_ctrl
// PURPOSE
//  Access controller for the unified buffer (simple dual-port RAM, 1-cycle read latency).
//  Arbitrates two write requesters (host load, accumulator writeback) onto the single write port.
//  Sequences burst reads of consecutive rows onto the read port and streams the returned rows to
//  the systolic-array feeder, with valid/last flags aligned to the read latency.
// PARAMETERS
//  ADDR_W  8    UB address width (depth = 2**ADDR_W rows)
//  DATA_W  128  UB row width
//  LEN_W   9    burst length width (ADDR_W+1, so a full-depth burst of 256 is legal)
// PORTS
//  clk            in   1       clock, all logic on posedge
//  rst_n          in   1       synchronous reset, active low
//  host_wr_valid  in   1       host write request
//  host_wr_ready  out  1       host write granted this cycle
//  host_wr_addr   in   ADDR_W  host write address
//  host_wr_data   in   DATA_W  host write data
//  acc_wr_valid   in   1       accumulator writeback request
//  acc_wr_ready   out  1       accumulator write granted this cycle
//  acc_wr_addr    in   ADDR_W  writeback address
//  acc_wr_data    in   DATA_W  writeback data
//  rd_cmd_valid   in   1       burst read command
//  rd_cmd_ready   out  1       command accepted (high only in IDLE)
//  rd_cmd_base    in   ADDR_W  first row of burst
//  rd_cmd_len     in   LEN_W   number of rows
//  ub_wea         out  1       UB write enable
//  ub_addra       out  ADDR_W  UB write address
//  ub_dina        out  DATA_W  UB write data
//  ub_enb         out  1       UB read enable
//  ub_addrb       out  ADDR_W  UB read address
//  ub_doutb       in   DATA_W  UB read data (valid 1 cycle after ub_enb)
//  rd_data_valid  out  1       rd_data holds a burst row
//  rd_data        out  DATA_W  row data (= ub_doutb, passthrough)
//  rd_data_last   out  1       final row of burst, qualified by rd_data_valid
//  busy           out  1       FSM not in IDLE or read data still in flight
// BEHAVIOUR
//  Reset: while rst_n=0 all readies, ub_wea, ub_enb = 0; on the edge: FSM->IDLE, rr pointer->host,
//   rd_data_valid/rd_data_last/busy = 0. Reset mid-burst aborts it; in-flight read is discarded.
//  Write arbiter (combinational grant, no latency):
//   - one valid only -> grant it; both valid -> grant rr pointer owner, pointer flips to the other.
//   - pointer changes only on a contended grant. ready = grant; ub_wea = any grant;
//     ub_addra/ub_dina muxed from the granted requester (hold last value when idle is not required).
//  Read FSM: IDLE -> ISSUE -> IDLE.
//   - IDLE: rd_cmd_ready=1. Accept on valid&ready: addr<=base, remaining<=len.
//     len=0: accepted, stays IDLE, no reads, no rd_data_valid.
//   - ISSUE: ub_enb=1, ub_addrb=addr; on issue addr<=addr+1 (wraps mod 2**ADDR_W), remaining-1;
//     issuing the last row -> IDLE. rd_cmd_ready=0 throughout ISSUE.
//   - Hazard: if ub_wea=1 and ub_addra==ub_addrb in the same cycle, ub_enb=0, no advance
//     (write wins; read retried next cycle, returns the new data).
//   - rd_data_valid registered = ub_enb delayed 1; rd_data_last = delayed "this issue was last".
//  Latency: command accepted cycle T -> first ub_enb T+1 -> first rd_data_valid T+2;
//   no-hazard burst of N occupies ub_enb T+1..T+N, data T+2..T+N+1; next command acceptable at T+N+1.
//  No back-pressure on read data; consumer takes every valid row.
//  busy = (state!=IDLE) | rd_data_valid.
// TESTING
//  1 host+acc valid every cycle, 4 cycles -> grants host,acc,host,acc; ub_addra follows winner.
//  2 burst base=0x10 len=4, no writes -> ub_addrb 0x10..0x13 cycles T+1..T+4; valid T+2..T+5; last at T+5.
//  3 burst base=0xFE len=4 -> addresses FE,FF,00,01; data matches preloaded rows.
//  4 burst base=0x20 len=3, acc writes 0x21 on 2nd issue cycle -> enb low 1 cycle, 0x21 read after,
//    returns new data; burst ends 1 cycle later.
//  5 len=0 -> ready stays 1, no ub_enb, no rd_data_valid; len=256 -> 256 rows, last on 256th.
//  6 rst_n low mid-burst (after 2 of 8 rows) -> next edge: enb 0, valid 0, busy 0, cmd_ready 1.

Source files
------------

// File: rtl/ub_access_ctrl_if.sv
// Unified-buffer access controller bus bundle.
// Carries the two write requester channels (host load, accumulator writeback),
// the burst read command channel, the UB RAM ports and the row stream to the
// systolic-array feeder.
//   slave  : the controller side (takes requests, drives grants, RAM ports, row stream)
//   master : the requester / RAM / consumer side
interface ub_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 9
);
    logic              host_wr_valid;
    logic              host_wr_ready;
    logic [ADDR_W-1:0] host_wr_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              acc_wr_valid;
    logic              acc_wr_ready;
    logic [ADDR_W-1:0] acc_wr_addr;
    logic [DATA_W-1:0] acc_wr_data;
    logic              rd_cmd_valid;
    logic              rd_cmd_ready;
    logic [ADDR_W-1:0] rd_cmd_base;
    logic [LEN_W-1:0]  rd_cmd_len;
    logic              ub_wea;
    logic [ADDR_W-1:0] ub_addra;
    logic [DATA_W-1:0] ub_dina;
    logic              ub_enb;
    logic [ADDR_W-1:0] ub_addrb;
    logic [DATA_W-1:0] ub_doutb;
    logic              rd_data_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_last;
    logic              busy;

    modport slave (
        input  host_wr_valid, host_wr_addr, host_wr_data,
        input  acc_wr_valid, acc_wr_addr, acc_wr_data,
        input  rd_cmd_valid, rd_cmd_base, rd_cmd_len,
        input  ub_doutb,
        output host_wr_ready, acc_wr_ready, rd_cmd_ready,
        output ub_wea, ub_addra, ub_dina, ub_enb, ub_addrb,
        output rd_data_valid, rd_data, rd_data_last, busy
    );

    modport master (
        output host_wr_valid, host_wr_addr, host_wr_data,
        output acc_wr_valid, acc_wr_addr, acc_wr_data,
        output rd_cmd_valid, rd_cmd_base, rd_cmd_len,
        output ub_doutb,
        input  host_wr_ready, acc_wr_ready, rd_cmd_ready,
        input  ub_wea, ub_addra, ub_dina, ub_enb, ub_addrb,
        input  rd_data_valid, rd_data, rd_data_last, busy
    );
endinterface

// File: rtl/ub_access_ctrl.sv
// Unified-buffer access controller.
// - Round-robin arbiter puts host load / accumulator writeback onto the single
//   UB write port with a combinational grant.
// - Read FSM (IDLE -> ISSUE -> IDLE) walks a burst of consecutive rows on the
//   UB read port and streams returned rows with valid/last aligned to the
//   1-cycle RAM read latency.
// Ports:
//   clk    : clock, posedge
//   rst_n  : synchronous reset, active low
//   bus    : ub_access_ctrl_if.slave (write requesters, read command, UB ports,
//            row stream, busy)
module ub_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128,
    parameter int LEN_W  = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ub_access_ctrl_if.slave      bus
);
    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [LEN_W-1:0]  remaining, remaining_nxt;
    logic              rr_acc, rr_acc_nxt;   // 1: accumulator wins next contention
    logic              rd_vld, rd_last;

    logic              host_gnt, acc_gnt;
    logic [ADDR_W-1:0] wr_addr;
    logic              hazard, issue, issue_last, cmd_ready;

    // Write arbiter: grants are gated by rst_n so nothing reaches the RAM
    // while reset is held.
    always_comb begin
        host_gnt   = 1'b0;
        acc_gnt    = 1'b0;
        rr_acc_nxt = rr_acc;
        if (rst_n) begin
            if (bus.host_wr_valid && bus.acc_wr_valid) begin
                acc_gnt    = rr_acc;
                host_gnt   = !rr_acc;
                rr_acc_nxt = !rr_acc;
            end else begin
                host_gnt = bus.host_wr_valid;
                acc_gnt  = bus.acc_wr_valid;
            end
        end
    end

    assign wr_addr = acc_gnt ? bus.acc_wr_addr : bus.host_wr_addr;

    // Write wins a same-row collision; the read is simply retried next cycle
    // and then sees the freshly written row.
    assign hazard     = (host_gnt || acc_gnt) && (wr_addr == addr);
    assign issue_last = (remaining == LEN_W'(1));

    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        cmd_ready     = 1'b0;
        issue         = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = rst_n;
                if (rst_n && bus.rd_cmd_valid) begin
                    addr_nxt      = bus.rd_cmd_base;
                    remaining_nxt = bus.rd_cmd_len;
                    // A zero-length command is consumed without any reads.
                    if (bus.rd_cmd_len != '0)
                        state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (rst_n && !hazard) begin
                    issue         = 1'b1;
                    addr_nxt      = addr + ADDR_W'(1);   // wraps around the buffer
                    remaining_nxt = remaining - LEN_W'(1);
                    if (issue_last)
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            rr_acc    <= 1'b0;
            rd_vld    <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr      <= addr_nxt;
            remaining <= remaining_nxt;
            rr_acc    <= rr_acc_nxt;
            rd_vld    <= issue;
            rd_last   <= issue && issue_last;
        end
    end

    assign bus.host_wr_ready = host_gnt;
    assign bus.acc_wr_ready  = acc_gnt;
    assign bus.ub_wea        = host_gnt || acc_gnt;
    assign bus.ub_addra      = wr_addr;
    assign bus.ub_dina       = acc_gnt ? bus.acc_wr_data : bus.host_wr_data;

    assign bus.rd_cmd_ready  = cmd_ready;
    assign bus.ub_enb        = issue;
    assign bus.ub_addrb      = addr;

    assign bus.rd_data_valid = rd_vld;
    assign bus.rd_data       = bus.ub_doutb;
    assign bus.rd_data_last  = rd_last;
    assign bus.busy          = (state != S_IDLE) || rd_vld;
endmodule

// File: tb/tb_ub_access_ctrl.sv
// Bench for ub_access_ctrl: behavioural UB RAM, reference row memory,
// round-robin grant model and a burst scoreboard.
module tb_ub_access_ctrl;
    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;

    ub_access_ctrl_if bus ();

    ub_access_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural UB RAM, one cycle read latency.
    logic [127:0] mem [256];
    always @(posedge clk) begin
        if (bus.ub_wea) mem[bus.ub_addra] <= bus.ub_dina;
        if (bus.ub_enb) bus.ub_doutb <= mem[bus.ub_addrb];
    end

    // Reference contents as the bench expects them after every granted write.
    logic [127:0] ref_mem [256];
    bit           m_prio_acc;   // model: accumulator owns the next contended grant

    // Burst monitor.
    int           enb_cyc_q [$];
    logic [7:0]   enb_addr_q[$];
    logic [127:0] row_q     [$];
    int           row_cyc_q [$];
    bit           last_q    [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ub_enb) begin
                enb_cyc_q.push_back(cyc);
                enb_addr_q.push_back(bus.ub_addrb);
            end
            if (bus.rd_data_valid) begin
                row_q.push_back(bus.rd_data);
                row_cyc_q.push_back(cyc);
                last_q.push_back(bus.rd_data_last);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clear_mon;
        enb_cyc_q.delete();
        enb_addr_q.delete();
        row_q.delete();
        row_cyc_q.delete();
        last_q.delete();
    endtask

    // One write cycle with the given requests; checks grants against the
    // round-robin model and records the winning write in ref_mem.
    task automatic wr_cycle(input bit hv, input logic [7:0] ha, input logic [127:0] hd,
                            input bit av, input logic [7:0] aa, input logic [127:0] ad);
        bit exp_h, exp_a;
        bus.host_wr_valid = hv; bus.host_wr_addr = ha; bus.host_wr_data = hd;
        bus.acc_wr_valid  = av; bus.acc_wr_addr  = aa; bus.acc_wr_data  = ad;
        @(negedge clk);
        if (hv && av) begin
            exp_a      = m_prio_acc;
            exp_h      = !m_prio_acc;
            m_prio_acc = !m_prio_acc;
        end else begin
            exp_h = hv;
            exp_a = av;
        end
        chk("host_rdy", bus.host_wr_ready, exp_h);
        chk("acc_rdy",  bus.acc_wr_ready,  exp_a);
        chk("wea",      bus.ub_wea,        exp_h | exp_a);
        if (exp_a) begin
            chk("addra_acc", bus.ub_addra, aa);
            chk("dina_acc",  bus.ub_dina,  ad);
            ref_mem[aa] = ad;
        end else if (exp_h) begin
            chk("addra_host", bus.ub_addra, ha);
            chk("dina_host",  bus.ub_dina,  hd);
            ref_mem[ha] = hd;
        end
        tick;
        bus.host_wr_valid = 1'b0;
        bus.acc_wr_valid  = 1'b0;
    endtask

    // Issue one burst with no concurrent writes and score the returned rows.
    task automatic run_burst(input logic [7:0] base, input int len, input bit timing);
        int         t0;
        int         w;
        logic [7:0] a;
        clear_mon();
        bus.rd_cmd_valid = 1'b1;
        bus.rd_cmd_base  = base;
        bus.rd_cmd_len   = 9'(len);
        @(negedge clk);
        chk("cmd_rdy", bus.rd_cmd_ready, 1'b1);
        t0 = cyc;
        tick;
        bus.rd_cmd_valid = 1'b0;
        w = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            w++;
            if (w > len + 20) begin
                chk("burst_timeout", 1'b1, 1'b0);
                break;
            end
            tick;
        end
        chk("idle_rdy", bus.rd_cmd_ready, 1'b1);
        tick;
        chk("n_issue", enb_addr_q.size(), len);
        chk("n_rows",  row_q.size(),      len);
        for (int i = 0; i < len && i < row_q.size() && i < enb_addr_q.size(); i++) begin
            a = 8'(int'(base) + i);
            chk("rd_addr", enb_addr_q[i], a);
            chk("rd_data", row_q[i], ref_mem[a]);
            chk("rd_last", last_q[i], i == len - 1);
            if (timing) begin
                chk("enb_cyc", enb_cyc_q[i], t0 + 1 + i);
                chk("vld_cyc", row_cyc_q[i], t0 + 2 + i);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d;
        int           t0;
        int           w;
        n_chk = 0;
        n_err = 0;
        m_prio_acc = 1'b0;
        rst_n = 1'b0;
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 8'h01; bus.host_wr_data = '0;
        bus.acc_wr_valid  = 1'b1; bus.acc_wr_addr  = 8'h02; bus.acc_wr_data  = '0;
        bus.rd_cmd_valid  = 1'b1; bus.rd_cmd_base  = 8'h00; bus.rd_cmd_len   = 9'd4;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) tick;

        // Reset state: requests present but nothing may be granted or issued.
        @(negedge clk);
        chk("rst_host_rdy", bus.host_wr_ready, 1'b0);
        chk("rst_acc_rdy",  bus.acc_wr_ready,  1'b0);
        chk("rst_cmd_rdy",  bus.rd_cmd_ready,  1'b0);
        chk("rst_wea",      bus.ub_wea,        1'b0);
        chk("rst_enb",      bus.ub_enb,        1'b0);
        chk("rst_vld",      bus.rd_data_valid, 1'b0);
        chk("rst_busy",     bus.busy,          1'b0);
        tick;
        bus.host_wr_valid = 1'b0;
        bus.acc_wr_valid  = 1'b0;
        bus.rd_cmd_valid  = 1'b0;
        rst_n = 1'b1;

        // Contended writes: host, acc, host, acc.
        for (int i = 0; i < 4; i++) begin
            bus.host_wr_valid = 1'b1; bus.host_wr_addr = 8'(8'h80 + i); bus.host_wr_data = rnd128();
            bus.acc_wr_valid  = 1'b1; bus.acc_wr_addr  = 8'(8'hC0 + i); bus.acc_wr_data  = rnd128();
            @(negedge clk);
            chk("rr_host", bus.host_wr_ready, (i % 2) == 0);
            chk("rr_acc",  bus.acc_wr_ready,  (i % 2) == 1);
            chk("rr_addra", bus.ub_addra, (i % 2) == 0 ? 8'(8'h80 + i) : 8'(8'hC0 + i));
            if ((i % 2) == 0) ref_mem[8'(8'h80 + i)] = bus.host_wr_data;
            else              ref_mem[8'(8'hC0 + i)] = bus.acc_wr_data;
            tick;
        end
        bus.host_wr_valid = 1'b0;
        bus.acc_wr_valid  = 1'b0;
        // Four contended grants leave ownership back at host.
        m_prio_acc = 1'b0;

        // Preload every row through the host port.
        for (int a = 0; a < 256; a++) wr_cycle(1'b1, 8'(a), rnd128(), 1'b0, 8'h00, '0);

        // Plain burst with exact timing, then a wrapping one.
        run_burst(8'h10, 4, 1'b1);
        run_burst(8'hFE, 4, 1'b1);

        // Accumulator writes the row being read on the second issue cycle.
        clear_mon();
        bus.rd_cmd_valid = 1'b1; bus.rd_cmd_base = 8'h20; bus.rd_cmd_len = 9'd3;
        @(negedge clk);
        t0 = cyc;
        tick;
        bus.rd_cmd_valid = 1'b0;
        tick;
        d = rnd128();
        bus.acc_wr_valid = 1'b1; bus.acc_wr_addr = 8'h21; bus.acc_wr_data = d;
        @(negedge clk);
        chk("hz_acc_rdy", bus.acc_wr_ready, 1'b1);
        chk("hz_enb",     bus.ub_enb,       1'b0);
        ref_mem[8'h21] = d;
        tick;
        bus.acc_wr_valid = 1'b0;
        w = 0;
        forever begin
            @(negedge clk);
            if (!bus.busy) break;
            w++;
            if (w > 20) begin
                chk("hz_timeout", 1'b1, 1'b0);
                break;
            end
            tick;
        end
        tick;
        chk("hz_n_rows", row_q.size(), 3);
        chk("hz_n_issue", enb_addr_q.size(), 3);
        if (row_q.size() == 3 && enb_addr_q.size() == 3) begin
            chk("hz_addr0", enb_addr_q[0], 8'h20);
            chk("hz_addr1", enb_addr_q[1], 8'h21);
            chk("hz_addr2", enb_addr_q[2], 8'h22);
            chk("hz_enb_cyc1", enb_cyc_q[1], t0 + 3);
            chk("hz_data0", row_q[0], ref_mem[8'h20]);
            chk("hz_data1", row_q[1], d);
            chk("hz_data2", row_q[2], ref_mem[8'h22]);
            chk("hz_last", {last_q[0], last_q[1], last_q[2]}, 3'b001);
            chk("hz_end_cyc", row_cyc_q[2], t0 + 5);
        end

        // Zero-length and full-depth bursts.
        run_burst(8'h55, 0, 1'b1);
        run_burst(8'h37, 256, 1'b1);

        // Reset mid-burst; make acc own the next contention first so the
        // pointer reset is observable.
        while (!m_prio_acc) wr_cycle(1'b1, 8'h90, rnd128(), 1'b1, 8'h91, rnd128());
        clear_mon();
        bus.rd_cmd_valid = 1'b1; bus.rd_cmd_base = 8'h40; bus.rd_cmd_len = 9'd8;
        tick;
        bus.rd_cmd_valid = 1'b0;
        w = 0;
        forever begin
            @(negedge clk);
            if (row_q.size() >= 2) break;
            w++;
            if (w > 10) begin
                chk("mid_timeout", 1'b1, 1'b0);
                break;
            end
            tick;
        end
        tick;
        rst_n = 1'b0;
        bus.host_wr_valid = 1'b1; bus.host_wr_addr = 8'h95; bus.host_wr_data = rnd128();
        bus.acc_wr_valid  = 1'b1; bus.acc_wr_addr  = 8'h96; bus.acc_wr_data  = rnd128();
        @(negedge clk);
        chk("mrst_enb", bus.ub_enb, 1'b0);
        chk("mrst_wea", bus.ub_wea, 1'b0);
        tick;
        rst_n = 1'b1;
        m_prio_acc = 1'b0;
        @(negedge clk);
        chk("mrst_vld",     bus.rd_data_valid, 1'b0);
        chk("mrst_busy",    bus.busy,          1'b0);
        chk("mrst_cmd_rdy", bus.rd_cmd_ready,  1'b1);
        chk("mrst_enb2",    bus.ub_enb,        1'b0);
        chk("mrst_rr_host", bus.host_wr_ready, 1'b1);
        chk("mrst_rr_acc",  bus.acc_wr_ready,  1'b0);
        ref_mem[8'h95] = bus.host_wr_data;
        m_prio_acc = 1'b1;
        tick;
        bus.host_wr_valid = 1'b0;
        bus.acc_wr_valid  = 1'b0;
        tick;
        run_burst(8'h3E, 4, 1'b1);

        // Random writes interleaved with random bursts.
        for (int it = 0; it < 30; it++) begin
            int nw;
            nw = $urandom_range(0, 4);
            for (int k = 0; k < nw; k++)
                wr_cycle($urandom_range(0, 1) == 1, 8'($urandom), rnd128(),
                         $urandom_range(0, 1) == 1, 8'($urandom), rnd128());
            run_burst(8'($urandom), $urandom_range(0, 40), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
